// File: rtl/pdm_sample_feeder_pkg.sv
// Shared constants and types for the PDM sample feeder: register map,
// STATUS/CTRL bit positions and the output FSM state encoding.
package pdm_sample_feeder_pkg;

    localparam int unsigned RegW = 32;
    localparam int unsigned AdrW = 2;

    localparam logic [AdrW-1:0] ADR_DATA   = 2'd0;
    localparam logic [AdrW-1:0] ADR_DIV    = 2'd1;
    localparam logic [AdrW-1:0] ADR_STATUS = 2'd2;
    localparam logic [AdrW-1:0] ADR_CTRL   = 2'd3;

    localparam int unsigned ST_EMPTY    = 8;
    localparam int unsigned ST_FULL     = 9;
    localparam int unsigned ST_UNDERRUN = 10;
    localparam int unsigned ST_OVERFLOW = 11;
    localparam int unsigned ST_LATE     = 12;

    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_FLUSH = 1;

    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_SEND = 1'b1
    } out_state_e;

endpackage

// File: rtl/pdm_sample_feeder_if.sv
// Host Wishbone port plus downstream channel strobe port of the sample feeder.
interface pdm_sample_feeder_if
    import pdm_sample_feeder_pkg::*;
#(
    parameter int unsigned pBits = 8
);
    logic              host_stb;
    logic              host_we;
    logic [AdrW-1:0]   host_adr;
    logic [RegW-1:0]   host_dat_w;
    logic [RegW-1:0]   host_dat_r;
    logic              host_ack;
    logic              ch_stb;
    logic [pBits-1:0]  ch_dat;
    logic              ch_ack;

    // Environment side: drives the host bus, acknowledges the channel.
    modport master (
        output host_stb, host_we, host_adr, host_dat_w, ch_ack,
        input  host_dat_r, host_ack, ch_stb, ch_dat
    );

    // Feeder side.
    modport slave (
        input  host_stb, host_we, host_adr, host_dat_w, ch_ack,
        output host_dat_r, host_ack, ch_stb, ch_dat
    );
endinterface

// File: rtl/pdm_sample_fifo.sv
// Show-ahead sample FIFO with exact fill count; flush dominates push/pop,
// and a push into a full FIFO is accepted only when a pop frees a slot.
module pdm_sample_fifo #(
    parameter int unsigned pBits  = 8,
    parameter int unsigned pDepth = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [pBits-1:0]             wdata_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic [pBits-1:0]             rdata_o,
    output logic [$clog2(pDepth):0]      count_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int unsigned AW   = $clog2(pDepth);
    localparam int unsigned CntW = AW + 1;

    logic [pBits-1:0] mem_q [pDepth];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(pDepth));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/pdm_sample_feeder.sv
// Paces host-written PCM samples out to a PDM channel, one per programmable
// sample period, with sticky underrun/overflow/late reporting.
module pdm_sample_feeder
    import pdm_sample_feeder_pkg::*;
#(
    parameter int unsigned pBits    = 8,
    parameter int unsigned pDepth   = 16,
    parameter int unsigned pDivBits = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pdm_sample_feeder_if.slave   bus
);
    localparam int unsigned CntW = $clog2(pDepth) + 1;

    logic                wr_en, wr_data, wr_div, wr_status, wr_ctrl;
    logic [pDivBits-1:0] div_q, div_d, cnt_q, cnt_d;
    logic                en_q, en_d;
    logic                tick;
    logic                underrun_q, underrun_d, overflow_q, overflow_d, late_q, late_d;
    logic                set_under, set_over, set_late;
    out_state_e          state_q, state_d;
    logic                ch_stb_q, ch_stb_d;
    logic [pBits-1:0]    ch_dat_q, ch_dat_d;
    logic                flushed_q, flushed_d;
    logic                fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [pBits-1:0]    fifo_rdata;
    logic [CntW-1:0]     fifo_count;
    logic [RegW-1:0]     status, rd_dat;
    logic                unused_wdat;

    assign wr_en     = bus.host_stb & bus.host_we;
    assign wr_data   = wr_en & (bus.host_adr == ADR_DATA);
    assign wr_div    = wr_en & (bus.host_adr == ADR_DIV);
    assign wr_status = wr_en & (bus.host_adr == ADR_STATUS);
    assign wr_ctrl   = wr_en & (bus.host_adr == ADR_CTRL);

    assign fifo_flush = wr_ctrl & bus.host_dat_w[CTRL_FLUSH];
    assign fifo_push  = wr_data;
    assign tick       = en_q & (cnt_q == div_q);
    assign unused_wdat = ^bus.host_dat_w;

    pdm_sample_fifo #(.pBits(pBits), .pDepth(pDepth)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (bus.host_dat_w[pBits-1:0]),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Config registers and sample-period divider.
    always_comb begin
        div_d = div_q;
        en_d  = en_q;
        cnt_d = cnt_q + pDivBits'(1);
        if (wr_div)  div_d = bus.host_dat_w[pDivBits-1:0];
        if (wr_ctrl) en_d  = bus.host_dat_w[CTRL_EN];
        if (!en_q || wr_div || tick) cnt_d = '0;
    end

    // Output FSM; a flush that lands on a registered sample cancels its pop.
    always_comb begin
        state_d   = state_q;
        ch_stb_d  = ch_stb_q;
        ch_dat_d  = ch_dat_q;
        flushed_d = flushed_q;
        fifo_pop  = 1'b0;
        set_under = 1'b0;
        set_late  = 1'b0;
        case (state_q)
            OUT_IDLE: begin
                if (tick) begin
                    if (!fifo_empty) begin
                        state_d  = OUT_SEND;
                        ch_stb_d = 1'b1;
                        ch_dat_d = fifo_rdata;
                    end else begin
                        set_under = 1'b1;
                    end
                end
            end
            OUT_SEND: begin
                set_late = tick;
                if (bus.ch_ack) begin
                    fifo_pop = ~flushed_q & ~fifo_flush;
                    state_d  = OUT_IDLE;
                    ch_stb_d = 1'b0;
                end
            end
            default: state_d = OUT_IDLE;
        endcase
        if (state_d == OUT_IDLE)  flushed_d = 1'b0;
        else if (fifo_flush)      flushed_d = 1'b1;
    end

    // Sticky flags: a set in the same cycle as a clear wins.
    assign set_over   = fifo_push & fifo_full & ~fifo_pop & ~fifo_flush;
    assign underrun_d = (underrun_q & ~(wr_status & bus.host_dat_w[ST_UNDERRUN])) | set_under;
    assign overflow_d = (overflow_q & ~(wr_status & bus.host_dat_w[ST_OVERFLOW])) | set_over;
    assign late_d     = (late_q     & ~(wr_status & bus.host_dat_w[ST_LATE]))     | set_late;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= '0;
            cnt_q      <= '0;
            en_q       <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            late_q     <= 1'b0;
            state_q    <= OUT_IDLE;
            ch_stb_q   <= 1'b0;
            ch_dat_q   <= '0;
            flushed_q  <= 1'b0;
        end else begin
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            en_q       <= en_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
            late_q     <= late_d;
            state_q    <= state_d;
            ch_stb_q   <= ch_stb_d;
            ch_dat_q   <= ch_dat_d;
            flushed_q  <= flushed_d;
        end
    end

    always_comb begin
        status              = '0;
        status[7:0]         = 8'(fifo_count);
        status[ST_EMPTY]    = fifo_empty;
        status[ST_FULL]     = fifo_full;
        status[ST_UNDERRUN] = underrun_q;
        status[ST_OVERFLOW] = overflow_q;
        status[ST_LATE]     = late_q;
    end

    always_comb begin
        rd_dat = '0;
        case (bus.host_adr)
            ADR_DIV:    rd_dat = RegW'(div_q);
            ADR_STATUS: rd_dat = status;
            ADR_CTRL:   rd_dat[CTRL_EN] = en_q;
            default:    rd_dat = '0;
        endcase
    end

    assign bus.host_dat_r = rd_dat;
    assign bus.host_ack   = bus.host_stb;
    assign bus.ch_stb     = ch_stb_q;
    assign bus.ch_dat     = ch_dat_q;

endmodule

// File: tb/tb_pdm_sample_feeder.sv
// Directed bench for pdm_sample_feeder: pacing, underrun, overflow, late,
// sticky clear collisions and reset during a transfer.
module tb_pdm_sample_feeder;

    logic clk;
    logic rst;
    logic ack_tied;
    logic ack_man;
    int   vectors;
    int   miscompares;
    logic [31:0] rd;
    logic        exp_stb;
    int          n;
    logic [7:0]  exp_dat [3];

    pdm_sample_feeder_if #(.pBits(8)) bus ();

    pdm_sample_feeder #(.pBits(8), .pDepth(16), .pDivBits(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign bus.ch_ack = ack_tied ? bus.ch_stb : ack_man;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic wb_write(input logic [1:0] adr, input logic [31:0] d);
        bus.host_stb   = 1'b1;
        bus.host_we    = 1'b1;
        bus.host_adr   = adr;
        bus.host_dat_w = d;
        tick_clk();
        bus.host_stb   = 1'b0;
        bus.host_we    = 1'b0;
    endtask

    task automatic wb_read(input logic [1:0] adr, output logic [31:0] d);
        bus.host_stb = 1'b1;
        bus.host_we  = 1'b0;
        bus.host_adr = adr;
        #1;
        d = bus.host_dat_r;
        bus.host_stb = 1'b0;
    endtask

    task automatic wait_stb(input string tag);
        for (int c = 0; c < 10 && !bus.ch_stb; c++) tick_clk();
        check(tag, 32'(bus.ch_stb), 32'd1);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        exp_dat = '{8'h10, 8'h20, 8'h80};
        rst = 1'b1;
        ack_tied = 1'b1;
        ack_man = 1'b0;
        bus.host_stb = 1'b0;
        bus.host_we = 1'b0;
        bus.host_adr = 2'd0;
        bus.host_dat_w = 32'd0;
        repeat (3) tick_clk();
        rst = 1'b0;
        tick_clk();

        // Reset state
        bus.host_stb = 1'b1; bus.host_adr = 2'd2; #1;
        check("host_ack", 32'(bus.host_ack), 32'd1);
        rd = bus.host_dat_r; bus.host_stb = 1'b0;
        check("rst_status", rd, 32'h100);
        check("rst_stb", 32'(bus.ch_stb), 32'd0);
        check("rst_dat", 32'(bus.ch_dat), 32'd0);
        wb_read(2'd1, rd); check("rst_div", rd, 32'd0);
        wb_read(2'd3, rd); check("rst_ctrl", rd, 32'd0);

        // Paced output, DIV=3 -> strobes every 4 cycles, then underrun
        wb_write(2'd1, 32'd3);
        wb_read(2'd1, rd); check("div_rb", rd, 32'd3);
        wb_write(2'd0, 32'h10);
        wb_write(2'd0, 32'h20);
        wb_write(2'd0, 32'h80);
        wb_read(2'd0, rd); check("data_rd", rd, 32'd0);
        wb_read(2'd2, rd); check("status_3", rd, 32'h003);
        wb_write(2'd3, 32'd1);
        for (int k = 1; k <= 16; k++) begin
            tick_clk();
            exp_stb = (k == 4) || (k == 8) || (k == 12);
            check($sformatf("pace_stb_k%0d", k), 32'(bus.ch_stb), 32'(exp_stb));
            if (exp_stb) check($sformatf("pace_dat_k%0d", k), 32'(bus.ch_dat), 32'(exp_dat[k/4-1]));
        end
        wb_read(2'd2, rd); check("underrun", rd, 32'h500);
        check("hold_dat", 32'(bus.ch_dat), 32'h80);
        wb_write(2'd3, 32'd0);
        repeat (4) tick_clk();
        check("no_stb_empty", 32'(bus.ch_stb), 32'd0);
        wb_write(2'd2, 32'h1C00);
        wb_read(2'd2, rd); check("clear_1", rd, 32'h100);

        // Overflow: 17 pushes into depth 16
        for (int i = 0; i < 17; i++) wb_write(2'd0, 32'hA0 + 32'(i));
        wb_read(2'd2, rd); check("overflow", rd, 32'hA10);
        wb_write(2'd1, 32'd0);
        wb_write(2'd3, 32'd1);
        n = 0;
        for (int c = 0; c < 60; c++) begin
            tick_clk();
            if (bus.ch_stb) begin
                check("drain_dat", 32'(bus.ch_dat), 32'hA0 + 32'(n));
                n++;
            end
        end
        check("drain_n", 32'(n), 32'd16);
        check("drain_last", 32'(bus.ch_dat), 32'hAF);
        wb_write(2'd3, 32'd0);
        wb_read(2'd2, rd); check("sticky_all", rd, 32'h1D00);
        wb_write(2'd2, 32'h1C00);
        wb_read(2'd2, rd); check("clear_2", rd, 32'h100);

        // Delayed ack with DIV=0: hold, late, one pop per ack
        ack_tied = 1'b0;
        wb_write(2'd0, 32'h11);
        wb_write(2'd0, 32'h22);
        wb_write(2'd3, 32'd1);
        wait_stb("slow_stb1");
        check("slow_dat1", 32'(bus.ch_dat), 32'h11);
        for (int c = 0; c < 3; c++) begin
            tick_clk();
            check("slow_hold_stb", 32'(bus.ch_stb), 32'd1);
            check("slow_hold_dat", 32'(bus.ch_dat), 32'h11);
        end
        wb_read(2'd2, rd); check("slow_cnt2", 32'(rd[7:0]), 32'd2);
        ack_man = 1'b1; tick_clk(); ack_man = 1'b0;
        check("slow_drop1", 32'(bus.ch_stb), 32'd0);
        wb_read(2'd2, rd); check("slow_cnt1", 32'(rd[7:0]), 32'd1);
        tick_clk();
        check("slow_stb2", 32'(bus.ch_stb), 32'd1);
        check("slow_dat2", 32'(bus.ch_dat), 32'h22);
        ack_man = 1'b1; tick_clk(); ack_man = 1'b0;
        check("slow_drop2", 32'(bus.ch_stb), 32'd0);
        wb_write(2'd3, 32'd0);
        wb_read(2'd2, rd); check("slow_status", rd, 32'h1500);

        // Sticky clear colliding with an underrun tick
        wb_write(2'd1, 32'd3);
        wb_write(2'd3, 32'd1);
        repeat (3) tick_clk();
        wb_write(2'd2, 32'h1C00);
        wb_read(2'd2, rd); check("set_wins", rd, 32'h500);
        wb_write(2'd3, 32'd0);
        wb_write(2'd2, 32'h1C00);
        wb_read(2'd2, rd); check("clear_3", rd, 32'h100);

        // Reset in the middle of a transfer
        for (int i = 1; i <= 5; i++) wb_write(2'd0, 32'(i));
        wb_write(2'd3, 32'd1);
        wait_stb("mid_stb");
        check("mid_dat", 32'(bus.ch_dat), 32'h01);
        wb_read(2'd2, rd); check("mid_cnt", 32'(rd[7:0]), 32'd5);
        rst = 1'b1;
        tick_clk();
        check("rst_mid_stb", 32'(bus.ch_stb), 32'd0);
        check("rst_mid_dat", 32'(bus.ch_dat), 32'd0);
        wb_read(2'd2, rd); check("rst_mid_status", rd, 32'h100);
        wb_read(2'd3, rd); check("rst_mid_ctrl", rd, 32'd0);
        wb_read(2'd1, rd); check("rst_mid_div", rd, 32'd0);
        rst = 1'b0;
        repeat (3) tick_clk();
        check("post_rst_stb", 32'(bus.ch_stb), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pdm_sample_feeder.md
Name: pdm_sample_feeder

Overview:
- Upstream stage of a PDM output channel. The host pushes PCM samples into a small FIFO over a Wishbone peripheral port.
- The block releases one sample per programmable sample period as a Wishbone write strobe to the downstream channel, which latches it as its PDM level.
- This decouples CPU write timing from the audio sample rate and reports underrun/overflow.

Parameters:
- pBits, 8, sample width; equals the downstream channel level width.
- pDepth, 16, FIFO depth in samples; power of two, ≥2.
- pDivBits, 16, width of the sample-period divider.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- host_stb  input  1  host Wishbone strobe (cyc folded in)
- host_we  input  1  host write enable
- host_adr  input  2  register address
- host_dat_w  input  32  host write data
- host_dat_r  output  32  host read data
- host_ack  output  1  host acknowledge
- ch_stb  output  1  strobe to PDM channel
- ch_dat  output  pBits  sample to PDM channel
- ch_ack  input  1  PDM channel acknowledge (may be combinational from ch_stb)

Behaviour:
- Host handshake: host_ack = host_stb, zero wait states. Reads are combinational from registers. Writes take effect at the clock edge where host_stb & host_we.
- Register map:
  - 0 DATA (W): push host_dat_w[pBits-1:0]. Reads return 0.
  - 1 DIV (R/W): [pDivBits-1:0] = sample period − 1.
  - 2 STATUS (R): [7:0] fill count, [8] empty, [9] full, [10] underrun, [11] overflow, [12] late. Writing 1 to bits 10..12 clears them.
  - 3 CTRL (R/W): [0] enable, [1] flush (self-clearing; empties the FIFO).
- Reset: FIFO empty, DIV=0, enable=0, all sticky bits 0, divider count 0, ch_stb=0, ch_dat=0.
- Divider:
  - Counter is held at 0 while enable=0.
  - When enabled, it increments each cycle. At count==DIV it reloads 0 and asserts an internal tick for one cycle.
  - DIV=0 gives a tick every cycle. A DIV write resets the counter to 0.
- Output FSM, 2 states:
  - IDLE, tick & !empty: register ch_dat=head, ch_stb=1 on the next cycle, go to SEND.
  - IDLE, tick & empty: stay IDLE, set underrun. ch_dat keeps its last value and no strobe is issued; the channel holds its level.
  - SEND: hold ch_stb and ch_dat stable until ch_ack. The cycle with ch_stb & ch_ack pops the FIFO, and the next cycle ch_stb=0 and state is IDLE.
  - SEND, tick arrives while still in SEND: tick dropped, set late.
- FIFO rules:
  - Push while full (and no pop this cycle): data dropped, set overflow, count unchanged.
  - Push and pop in the same cycle: count unchanged. A push into a full FIFO that also pops is accepted.
  - Pointers wrap modulo pDepth. Count is pDepth-accurate (log2(pDepth)+1 bits, zero-extended).
- Flush: empties the FIFO next cycle. If in SEND, the strobe still completes with the already-registered ch_dat, and the pop is suppressed.
- Disable: clearing enable while in SEND lets the pending transfer complete; no new ticks occur.
- Sticky-clear write and set event in the same cycle: set wins.
- rst mid-transfer: ch_stb drops on the next edge, FIFO empties, registers return to reset values.

Decomposition:
- Shared package: register address constants (DATA, DIV, STATUS, CTRL), STATUS/CTRL bit positions, output FSM state enum.
- One sub-module: pdm_sample_fifo.
  - Parameters pBits, pDepth.
  - Ports: push, wdata, pop, flush, rdata (head, show-ahead), count, full, empty.

Test Plan:
- Reset, then read STATUS → 0x100 (empty=1, count 0). ch_stb=0, ch_dat=0.
- Write DIV=3, push 0x10, 0x20, 0x80, CTRL=1, ch_ack tied to ch_stb → strobes exactly 4 cycles apart with ch_dat 0x10, 0x20, 0x80. Then ticks on empty → underrun=1; ch_dat stays 0x80 with no strobe.
- Push 17 samples with enable=0, pDepth=16 → count 16, full=1, overflow=1. The 17th value never appears on ch_dat.
- DIV=0, ch_ack delayed 3 cycles after ch_stb → ch_stb/ch_dat held stable for 3 cycles, late=1, exactly one pop per ack.
- Write STATUS with 0x1C00 → underrun/overflow/late cleared. If an underrun tick lands in the same cycle, underrun reads 1.
- Assert rst during SEND with 5 queued samples → next cycle ch_stb=0, count 0, CTRL=0, DIV=0.
